// File: rtl/du_pkg.sv
// Decode-to-execute way0 register types: packet layout, occupancy states, field widths.
// Field widths here fix the packet layout; the top-level parameters must agree with them.
package du_pkg;

    localparam int DU_XLEN     = 64;
    localparam int DU_PC_W     = 32;
    localparam int DU_PID_W    = 2;
    localparam int DU_RD_W     = 5;
    localparam int DU_OPCODE_W = 7;
    localparam int DU_FUNCT3_W = 3;
    localparam int DU_FUNCT7_W = 7;
    localparam int DU_SHAMT_W  = 6;

    typedef struct packed {
        logic [DU_RD_W-1:0]     rd_addr;
        logic                   rd_we;
        logic [DU_PC_W-1:0]     inst_addr;
        logic [DU_XLEN-1:0]     rs1_data;
        logic [DU_XLEN-1:0]     rs2_data;
        logic [DU_XLEN-1:0]     imm;
        logic [DU_OPCODE_W-1:0] op_code;
        logic [DU_FUNCT3_W-1:0] funct3;
        logic [DU_FUNCT7_W-1:0] funct7;
        logic [DU_SHAMT_W-1:0]  shamt;
        logic [DU_PID_W-1:0]    pid;
    } du_payload_t;

    localparam int DU_PAYLOAD_W = $bits(du_payload_t);

    // Encoding doubles as the held-packet count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } du_state_e;

endpackage

// File: rtl/du_slot.sv
// Load-enabled payload register; one-cycle latency, no flow control of its own.
module du_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_ld,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/du_register_way0.sv
// 2-entry in-order skid buffer between decode and execute; 1-cycle latency when empty.
// valid_o/ready_o come from registered state only, so the skid slot absorbs a late stall.
module du_register_way0
    import du_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int PC_W  = 32,
    parameter int PID_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  du_payload_t du_pkt_i,
    output logic        valid_o,
    input  logic        ready_i,
    output du_payload_t du_pkt_o,
    output logic [1:0]  occupancy_o
);

    if (XLEN != DU_XLEN || PC_W != DU_PC_W || PID_W != DU_PID_W) begin : g_width_mismatch
        $error("du_register_way0 parameters disagree with du_pkg field widths");
    end

    du_state_e   r_state;
    du_state_e   w_state_nxt;
    logic        w_push;
    logic        w_pop;
    logic        w_main_ld;
    logic        w_skid_ld;
    du_payload_t w_main_d;
    du_payload_t w_main_q;
    du_payload_t w_skid_q;

    assign valid_o     = (r_state != EMPTY);
    assign ready_o     = (r_state != FULL);
    assign occupancy_o = r_state;
    assign w_push      = valid_i && ready_o;
    assign w_pop       = valid_o && ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_main_ld   = 1'b0;
        w_skid_ld   = 1'b0;
        w_main_d    = du_pkt_i;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_main_ld   = 1'b1;
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    w_main_ld = 1'b1;
                end else if (w_push) begin
                    w_skid_ld   = 1'b1;
                    w_state_nxt = FULL;
                end else if (w_pop) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                // ready_o is low here, so only the skid-to-main advance can occur.
                if (w_pop) begin
                    w_main_ld   = 1'b1;
                    w_main_d    = w_skid_q;
                    w_state_nxt = ONE;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
        // Flush wins over everything; stale payload is left behind, only state empties.
        if (flush_i) begin
            w_state_nxt = EMPTY;
            w_main_ld   = 1'b0;
            w_skid_ld   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    du_slot #(.W(DU_PAYLOAD_W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ld  (w_main_ld),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    du_slot #(.W(DU_PAYLOAD_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ld  (w_skid_ld),
        .i_d   (du_pkt_i),
        .o_q   (w_skid_q)
    );

    assign du_pkt_o = w_main_q;

endmodule

// File: tb/tb_du_register_way0.sv
// Directed bench for du_register_way0: inputs driven and outputs sampled 1ns after posedge.
module tb_du_register_way0;
    import du_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    du_payload_t du_pkt_i;
    logic        valid_o;
    logic        ready_i;
    du_payload_t du_pkt_o;
    logic [1:0]  occupancy_o;

    int errors = 0;
    int checks = 0;

    du_register_way0 #(.XLEN(64), .PC_W(32), .PID_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .du_pkt_i    (du_pkt_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .du_pkt_o    (du_pkt_o),
        .occupancy_o (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic du_payload_t mk(input logic [1:0] pid, input logic [63:0] imm,
                                       input logic [31:0] addr);
        du_payload_t p;
        p           = '0;
        p.rd_addr   = 5'd7;
        p.rd_we     = 1'b1;
        p.inst_addr = addr;
        p.rs1_data  = 64'h1111_2222_3333_4444 ^ imm;
        p.rs2_data  = 64'h5555_6666_7777_8888;
        p.imm       = imm;
        p.op_code   = 7'h13;
        p.funct3    = 3'd5;
        p.funct7    = 7'h20;
        p.shamt     = 6'd9;
        p.pid       = pid;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [254:0] obs, input logic [254:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    du_payload_t exp_pkt;

    initial begin
        rst_n    = 1'b0;
        flush_i  = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        du_pkt_i = '0;
        #12;
        chk("rst_valid", 255'(valid_o), 255'(1'b0));
        chk("rst_ready", 255'(ready_o), 255'(1'b1));
        chk("rst_occ", 255'(occupancy_o), 255'(2'd0));
        chk("rst_pkt", du_pkt_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single packet through with EX ready.
        exp_pkt  = mk(2'd0, 64'd0, 32'h8000_0000);
        valid_i  = 1'b1;
        ready_i  = 1'b1;
        du_pkt_i = exp_pkt;
        tick();
        valid_i  = 1'b0;
        du_pkt_i = '1;
        chk("single_valid", 255'(valid_o), 255'(1'b1));
        chk("single_addr", 255'(du_pkt_o.inst_addr), 255'(32'h8000_0000));
        chk("single_occ", 255'(occupancy_o), 255'(2'd1));
        tick();
        chk("single_drain_valid", 255'(valid_o), 255'(1'b0));
        chk("single_drain_occ", 255'(occupancy_o), 255'(2'd0));

        // Fill both slots while stalled, third held on the input.
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        du_pkt_i = mk(2'd0, 64'hA0, 32'h100);
        tick();
        chk("fill1_occ", 255'(occupancy_o), 255'(2'd1));
        chk("fill1_ready", 255'(ready_o), 255'(1'b1));
        du_pkt_i = mk(2'd1, 64'hA1, 32'h104);
        tick();
        chk("fill2_occ", 255'(occupancy_o), 255'(2'd2));
        chk("fill2_ready", 255'(ready_o), 255'(1'b0));
        du_pkt_i = mk(2'd2, 64'hA2, 32'h108);
        tick();
        chk("full_hold_occ", 255'(occupancy_o), 255'(2'd2));
        ready_i = 1'b1;
        chk("order_pid0", du_pkt_o, mk(2'd0, 64'hA0, 32'h100));
        tick();
        chk("order_pid1", du_pkt_o, mk(2'd1, 64'hA1, 32'h104));
        chk("order_pid1_occ", 255'(occupancy_o), 255'(2'd1));
        tick();
        valid_i = 1'b0;
        chk("order_pid2", du_pkt_o, mk(2'd2, 64'hA2, 32'h108));
        chk("order_pid2_valid", 255'(valid_o), 255'(1'b1));
        tick();
        chk("order_drain_valid", 255'(valid_o), 255'(1'b0));

        // Streaming: eight back-to-back packets.
        valid_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            du_pkt_i = mk(2'(k), 64'(k), 32'h200 + 32'(4 * k));
            chk($sformatf("stream_ready_%0d", k), 255'(ready_o), 255'(1'b1));
            tick();
            chk($sformatf("stream_imm_%0d", k), 255'(du_pkt_o.imm), 255'(64'(k)));
            chk($sformatf("stream_valid_%0d", k), 255'(valid_o), 255'(1'b1));
        end
        valid_i = 1'b0;
        tick();
        chk("stream_drain_valid", 255'(valid_o), 255'(1'b0));

        // Stall with one packet held.
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        exp_pkt  = mk(2'd3, 64'hDEAD, 32'h300);
        du_pkt_i = exp_pkt;
        tick();
        valid_i  = 1'b0;
        du_pkt_i = mk(2'd0, 64'hFFFF, 32'hFFFF_FFFC);
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("stall_pkt_%0d", s), du_pkt_o, exp_pkt);
            chk($sformatf("stall_valid_%0d", s), 255'(valid_o), 255'(1'b1));
            tick();
        end

        // Flush from FULL with a packet offered in the flush cycle.
        valid_i  = 1'b1;
        du_pkt_i = mk(2'd1, 64'hBEEF, 32'h304);
        tick();
        chk("preflush_occ", 255'(occupancy_o), 255'(2'd2));
        flush_i  = 1'b1;
        ready_i  = 1'b1;
        du_pkt_i = mk(2'd2, 64'hBAD, 32'h308);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_valid", 255'(valid_o), 255'(1'b0));
        chk("flush_ready", 255'(ready_o), 255'(1'b1));
        chk("flush_occ", 255'(occupancy_o), 255'(2'd0));
        tick();
        chk("flush_no_ghost", 255'(valid_o), 255'(1'b0));
        valid_i  = 1'b1;
        exp_pkt  = mk(2'd3, 64'hC0DE, 32'h30C);
        du_pkt_i = exp_pkt;
        tick();
        valid_i = 1'b0;
        chk("postflush_pkt", du_pkt_o, exp_pkt);
        tick();

        // Asynchronous reset while FULL.
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        du_pkt_i = mk(2'd0, 64'h11, 32'h400);
        tick();
        du_pkt_i = mk(2'd1, 64'h22, 32'h404);
        tick();
        valid_i = 1'b0;
        chk("prereset_occ", 255'(occupancy_o), 255'(2'd2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 255'(valid_o), 255'(1'b0));
        chk("arst_pkt", du_pkt_o, '0);
        chk("arst_ready", 255'(ready_o), 255'(1'b1));
        chk("arst_occ", 255'(occupancy_o), 255'(2'd0));
        @(negedge clk);
        rst_n    = 1'b1;
        valid_i  = 1'b1;
        exp_pkt  = mk(2'd2, 64'h33, 32'h408);
        du_pkt_i = exp_pkt;
        tick();
        valid_i = 1'b0;
        chk("post_arst_occ", 255'(occupancy_o), 255'(2'd1));
        chk("post_arst_pkt", du_pkt_o, exp_pkt);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
